// File: rtl/ulpi_reg_arbiter_if.sv
// ULPI wrapper register-access port: the arbiter drives it as master,
// the ULPI wrapper answers as slave.
interface ulpi_reg_arbiter_if;
    logic       ULPI_READY;
    logic       ULPI_REG_EN;
    logic       ULPI_REG_RW;
    logic [5:0] ULPI_REG_ADDR;
    logic [7:0] ULPI_REG_DATA_I;
    logic [7:0] ULPI_REG_DATA_O;
    logic       ULPI_REG_DONE;
    logic       ULPI_REG_FAIL;

    modport master (
        input  ULPI_READY,
        input  ULPI_REG_DATA_O,
        input  ULPI_REG_DONE,
        input  ULPI_REG_FAIL,
        output ULPI_REG_EN,
        output ULPI_REG_RW,
        output ULPI_REG_ADDR,
        output ULPI_REG_DATA_I
    );

    modport slave (
        output ULPI_READY,
        output ULPI_REG_DATA_O,
        output ULPI_REG_DONE,
        output ULPI_REG_FAIL,
        input  ULPI_REG_EN,
        input  ULPI_REG_RW,
        input  ULPI_REG_ADDR,
        input  ULPI_REG_DATA_I
    );
endinterface

// File: rtl/ulpi_reg_arbiter.sv
// Round-robin arbiter sharing the ULPI register-access port between N_REQ
// requesters, with FAIL/timeout retry and per-requester done/error pulses.
module ulpi_reg_arbiter #(
    parameter int unsigned N_REQ       = 3,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic                 CLK_60M,
    input  logic                 NRST_A_USB,
    input  logic [N_REQ-1:0]     REQ_EN,
    input  logic [N_REQ-1:0]     REQ_RW,
    input  logic [6*N_REQ-1:0]   REQ_ADDR,
    input  logic [8*N_REQ-1:0]   REQ_WDATA,
    output logic [N_REQ-1:0]     REQ_DONE,
    output logic [N_REQ-1:0]     REQ_ERR,
    output logic [7:0]           REQ_RDATA,
    output logic [N_REQ-1:0]     GRANT,
    output logic                 BUSY,
    ulpi_reg_arbiter_if.master   ulpi
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned SUM_W = IDX_W + 1;
    localparam int unsigned RTY_W = 3;
    localparam int unsigned TMO_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   last_grant;
    logic [RTY_W-1:0]   retry_cnt;
    logic [TMO_W-1:0]   timeout_cnt;
    logic               txn_rw;
    logic [5:0]         txn_addr;
    logic [7:0]         txn_wdata;

    logic               sel_valid;
    logic [IDX_W-1:0]   sel_idx;
    logic               drive_bus;
    logic               attempt_failed;

    // (base + off) mod N_REQ for base < N_REQ and off <= N_REQ
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
        logic [SUM_W-1:0] s;
        s = SUM_W'(base) + SUM_W'(off);
        if (s >= SUM_W'(N_REQ)) begin
            s = s - SUM_W'(N_REQ);
        end
        return IDX_W'(s);
    endfunction

    // Highest offset first, so the nearest requester after last_grant wins
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int k = int'(N_REQ); k >= 1; k--) begin
            if (REQ_EN[wrap_idx(last_grant, k)]) begin
                sel_valid = 1'b1;
                sel_idx   = wrap_idx(last_grant, k);
            end
        end
    end

    assign attempt_failed = ulpi.ULPI_REG_FAIL || (timeout_cnt == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
        if (!NRST_A_USB) begin
            state       <= ST_IDLE;
            last_grant  <= IDX_W'(N_REQ - 1);
            retry_cnt   <= '0;
            timeout_cnt <= '0;
            txn_rw      <= 1'b0;
            txn_addr    <= '0;
            txn_wdata   <= '0;
            GRANT       <= '0;
            REQ_DONE    <= '0;
            REQ_ERR     <= '0;
            REQ_RDATA   <= '0;
        end else begin
            REQ_DONE <= '0;
            REQ_ERR  <= '0;
            case (state)
                ST_IDLE: begin
                    if (sel_valid) begin
                        txn_rw     <= REQ_RW[sel_idx];
                        txn_addr   <= REQ_ADDR[6*sel_idx +: 6];
                        txn_wdata  <= REQ_WDATA[8*sel_idx +: 8];
                        GRANT      <= N_REQ'(1) << sel_idx;
                        last_grant <= sel_idx;
                        retry_cnt  <= '0;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (ulpi.ULPI_READY) begin
                        timeout_cnt <= '0;
                        state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    timeout_cnt <= timeout_cnt + TMO_W'(1);
                    // DONE takes precedence over FAIL and over the timeout
                    if (ulpi.ULPI_REG_DONE) begin
                        if (!txn_rw) begin
                            REQ_RDATA <= ulpi.ULPI_REG_DATA_O;
                        end
                        REQ_DONE <= GRANT;
                        state    <= ST_RESP;
                    end else if (attempt_failed) begin
                        if (retry_cnt < RTY_W'(MAX_RETRY)) begin
                            retry_cnt <= retry_cnt + RTY_W'(1);
                            state     <= ST_ISSUE;
                        end else begin
                            REQ_ERR <= GRANT;
                            state   <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    GRANT <= '0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus fields are only presented while an access is in flight
    assign drive_bus            = (state == ST_ISSUE) || (state == ST_WAIT);
    assign BUSY                 = (state != ST_IDLE);
    assign ulpi.ULPI_REG_EN     = (state == ST_ISSUE) && ulpi.ULPI_READY;
    assign ulpi.ULPI_REG_RW     = drive_bus & txn_rw;
    assign ulpi.ULPI_REG_ADDR   = drive_bus ? txn_addr  : 6'd0;
    assign ulpi.ULPI_REG_DATA_I = drive_bus ? txn_wdata : 8'd0;

endmodule
